// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin shared binary-to-BCD (double-dabble) converter
// Optional: define BCD_CLAMP_99_EN to clamp results above 99 to 99 with ovf set.
module bcd_conv_sched #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*7-1:0]   bin_flat,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic [PTR_W-1:0]    grant_id,
    output logic                done,
    output logic [3:0]          hundreds,
    output logic [3:0]          tens,
    output logic [3:0]          ones,
    output logic                ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [2:0]       cnt;
    logic [6:0]       shreg;
    logic [3:0]       wh, wt, wo;

    logic             found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cand;
    logic [6:0]       sel_bin;
    int               cand_i;

    logic [3:0]       ah, at, ao;
    logic [3:0]       wh_n, wt_n, wo_n;
    logic [6:0]       shreg_n;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Round-robin scan: first asserted req at or above ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        cand    = '0;
        cand_i  = 0;
        sel_bin = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_i = int'(ptr) + i;
            if (cand_i >= NREQ) begin
                cand_i = cand_i - NREQ;
            end
            cand = PTR_W'(cand_i);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (int'(sel) == k) begin
                sel_bin = bin_flat[k*7 +: 7];
            end
        end
    end

    // One double-dabble step: correct each digit, then shift the whole chain left.
    always_comb begin
        ah      = add3(wh);
        at      = add3(wt);
        ao      = add3(wo);
        wh_n    = {ah[2:0], at[3]};
        wt_n    = {at[2:0], ao[3]};
        wo_n    = {ao[2:0], shreg[6]};
        shreg_n = {shreg[5:0], 1'b0};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            shreg    <= '0;
            wh       <= '0;
            wt       <= '0;
            wo       <= '0;
            grant_id <= '0;
            done     <= 1'b0;
            ack      <= '0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            ack   <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        shreg    <= sel_bin;
                        wh       <= '0;
                        wt       <= '0;
                        wo       <= '0;
                        grant_id <= sel;
                        ptr      <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
                        cnt      <= 3'd7;
                    end
                end
                SHIFT: begin
                    wh    <= wh_n;
                    wt    <= wt_n;
                    wo    <= wo_n;
                    shreg <= shreg_n;
                    cnt   <= cnt - 3'd1;
                    // Result registers are loaded as the last shift lands, so they
                    // are valid for the whole DONE cycle alongside done/ack.
                    if (cnt == 3'd1) begin
                        done <= 1'b1;
                        ack  <= NREQ'(1) << grant_id;
`ifdef BCD_CLAMP_99_EN
                        if (wh_n != 4'd0) begin
                            hundreds <= 4'd0;
                            tens     <= 4'd9;
                            ones     <= 4'd9;
                        end else begin
                            hundreds <= wh_n;
                            tens     <= wt_n;
                            ones     <= wo_n;
                        end
`else
                        hundreds <= wh_n;
                        tens     <= wt_n;
                        ones     <= wo_n;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_CLAMP_99_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && cnt == 3'd1) begin
            ovf <= (wh_n != 4'd0);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
Shared binary-to-BCD conversion engine with a round-robin scheduler.
Up to NREQ requesters (score, timer and counter displays) each present a 7-bit binary value. The block grants one requester at a time, runs a sequential shift-add-3 (double-dabble) conversion at one bit per clock, and returns hundreds/tens/ones with a per-requester ack pulse.
It replaces per-display combinational converters with one time-shared, fully 0..127-correct converter.

Parameters:
NREQ, 4, number of requesters (2..8)
PTR_W, 2, width of the grant index; must be ≥ clog2(NREQ)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester conversion request, level, held until ack
bin_flat  input  NREQ*7  requester k value at bits [7k+6:7k]
ack  output  NREQ  one-cycle pulse to the served requester, coincident with done
busy  output  1  high whenever state is not IDLE
grant_id  output  PTR_W  index of requester currently/last served
done  output  1  one-cycle pulse, result valid
hundreds  output  4  BCD hundreds digit of last result
tens  output  4  BCD tens digit of last result
ones  output  4  BCD ones digit of last result
ovf  output  1  last value exceeded 99 (only driven when BCD_CLAMP_99_EN is defined, else constant 0)

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE, round-robin pointer=0, bit counter=0.
  - All outputs 0: ack, busy, grant_id, done, digits, ovf.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, when any req bit is high:
  - Pick the first asserted req scanning upward from pointer, wrapping at NREQ-1 to 0.
  - Latch that requester's 7-bit value into the shift register. Clear the working digits.
  - Set grant_id; set pointer = granted index + 1 (mod NREQ).
  - Counter=7; go to SHIFT.
- SHIFT, each cycle:
  - For each working digit ≥5, add 3 (4-bit).
  - Then shift {hundreds,tens,ones,shreg} left by 1. Decrement counter.
  - When the counter reaches 0 after the 7th shift, go to DONE.
- DONE: output digit registers load the working digits; done=1 and ack[grant_id]=1 for exactly this cycle; next state IDLE.
- Latency: req sampled in IDLE at cycle T; done/ack at T+8; earliest next grant at T+9. Back-to-back throughput is one conversion per 9 cycles.
- Input handling during a conversion:
  - bin_flat is sampled only at grant; later changes are ignored.
  - A req dropping mid-conversion does not abort it; its ack still pulses.
  - New reqs arriving while busy wait for IDLE.
- A requester still holding req in the IDLE cycle after its ack is eligible again, behind any other pending reqs per pointer order.
- Digit outputs hold their value between done pulses. Only DONE updates them.
- Output ranges: hundreds is 0 or 1; tens and ones are 0..9.
- Reset asserted mid-SHIFT aborts: no done/ack, outputs cleared, pointer=0.

Optional Feature:
BCD_CLAMP_99_EN
- Defined: a latched value >99 produces hundreds=0, tens=9, ones=9, ovf=1 at DONE. Values ≤99 produce ovf=0.
- Not defined: full three-digit result (0..127); ovf tied to 0.

Test Plan:
- Single request: req=0001, value 45 at T -> done and ack[0] at T+8; hundreds=0, tens=4, ones=5; busy high T+1..T+8.
- Boundaries: values 0, 9, 99, 100, 127 -> 0/0/0, 0/0/9, 0/9/9, 1/0/0, 1/2/7. With BCD_CLAMP_99_EN: 100 and 127 -> 0/9/9 with ovf=1; 99 -> ovf=0.
- All four reqs high from reset release, values 10, 20, 30, 40 -> grants 0, 1, 2, 3 in order; done pulses 9 cycles apart; results 10, 20, 30, 40 match grant_id.
- Round-robin fairness: after serving requester 2, reqs 0 and 3 pending -> 3 served before 0. Persistent req 1 does not starve req 3.
- Input change: bin for requester 0 changes 45->77 two cycles after grant -> result still 4/5, ack[0] still pulses.
- Reset mid-conversion: assert reset at T+4 -> no done/ack; all outputs 0; next grant starts from pointer 0.
